// File: rtl/mdu_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock, LO = quotient, HI = remainder.
// Latency WIDTH+2 edges from start to done (1 edge for divide-by-zero); start is ignored while busy or in DONE.
`timescale 1ns/1ps
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;

  always_comb begin
    trial  = {p, a[WIDTH-1]};
    diff   = trial - {1'b0, b};
    // The stored remainder is always below the divisor, so the borrow out of
    // the WIDTH+1-bit subtraction is exactly "trial < divisor".
    ge     = ~diff[WIDTH];
    dd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dv_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a           <= '0;
      b           <= '0;
      p           <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= is_signed & dividend[WIDTH-1];
            b           <= dv_mag;
            p           <= '0;
            cnt         <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              // Keep the raw dividend: it becomes the remainder unchanged.
              dz    <= 1'b1;
              a     <= dividend;
              state <= DONE;
            end else begin
              dz    <= 1'b0;
              a     <= dd_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          a   <= {a[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -a : a;
          remainder <= neg_r ? -p : p;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (dz) begin
            quotient    <= '1;
            remainder   <= a;
            div_by_zero <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
